// File: rtl/paint_cmd_rx_if.sv
// SPI-side inputs and pixel-write outputs of the paint command receiver.
interface paint_cmd_rx_if;
    logic       sck;
    logic       sdi;
    logic       cs;
    logic       wr_en;
    logic [7:0] wx;
    logic [7:0] wy;
    logic [2:0] new_color;
    logic       brush;
    logic       frame_err;

    modport master (
        output sck, sdi, cs,
        input  wr_en, wx, wy, new_color, brush, frame_err
    );

    modport slave (
        input  sck, sdi, cs,
        output wr_en, wx, wy, new_color, brush, frame_err
    );
endinterface

// File: rtl/paint_cmd_rx.sv
// SPI-slave command receiver: 3-byte commands -> pixel write pulses and
// held colour/brush state, all in the pixel clock domain.
module paint_cmd_rx #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] RESET_COLOR = 3'b101
) (
    input  logic           clk,
    input  logic           reset,
    paint_cmd_rx_if.slave  bus
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, cs_sync;
    logic                   sck_hist;
    logic                   sck_s, sdi_s, cs_s, sck_rise;
    logic                   shift_en, abort, boundary;

    logic [7:0] shreg, cmd, xb, yb;
    logic [2:0] bit_cnt;
    logic [1:0] byte_cnt;
    logic       byte_done;   // shreg holds a complete byte
    logic       cmd_rdy;     // cmd/xb/yb hold a complete command
    logic       err_p, err_q;

    logic       wr_en_q, frame_err_q, brush_q;
    logic [7:0] wx_q, wy_q;
    logic [2:0] color_q;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_hist;

    // A command boundary: nothing shifted, and either no byte pending or the
    // final byte of a command is about to be stored.
    assign boundary = (bit_cnt == 3'd0) &&
                      (byte_done ? (byte_cnt == 2'd2) : (byte_cnt == 2'd0));

    // Synchronise the asynchronous serial inputs; cs idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync <= '0;
            sdi_sync <= '0;
            cs_sync  <= '1;
            sck_hist <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], bus.sdi};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
            sck_hist <= sck_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state; a cs rise outranks an sck rise in the same cycle.
    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE:  if (!cs_s) state_d = SHIFT;
            SHIFT: begin
                if (cs_s) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else begin
                    shift_en = sck_rise;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit/byte assembly; a completed command finishes decoding even if cs
    // rises right after its last bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg     <= '0;
            cmd       <= '0;
            xb        <= '0;
            yb        <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            byte_done <= 1'b0;
            cmd_rdy   <= 1'b0;
            err_p     <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            cmd_rdy   <= 1'b0;
            err_p     <= 1'b0;
            if (shift_en) begin
                shreg   <= {shreg[6:0], sdi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) byte_done <= 1'b1;
            end
            if (byte_done) begin
                case (byte_cnt)
                    2'd0:    cmd <= shreg;
                    2'd1:    xb  <= shreg;
                    default: yb  <= shreg;
                endcase
                if (byte_cnt == 2'd2) begin
                    byte_cnt <= 2'd0;
                    cmd_rdy  <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end
            if (abort) begin
                bit_cnt <= '0;
                err_p   <= ~boundary;
                if (!boundary) begin
                    byte_cnt <= '0;
                    cmd_rdy  <= 1'b0;
                end
            end
        end
    end

    // Decode and registered outputs; abort errors are delayed to line up
    // with the command-decode latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            wx_q        <= '0;
            wy_q        <= '0;
            color_q     <= RESET_COLOR;
            brush_q     <= 1'b0;
        end else begin
            err_q       <= err_p;
            wr_en_q     <= 1'b0;
            frame_err_q <= err_q;
            if (cmd_rdy) begin
                case (cmd[7:4])
                    4'h1: begin
                        wr_en_q <= 1'b1;
                        wx_q    <= xb;
                        wy_q    <= yb;
                    end
                    4'h2: begin
                        color_q <= cmd[2:0];
                        brush_q <= cmd[3];
                    end
                    default: frame_err_q <= 1'b1;
                endcase
            end
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.frame_err = frame_err_q;
    assign bus.wx        = wx_q;
    assign bus.wy        = wy_q;
    assign bus.new_color = color_q;
    assign bus.brush     = brush_q;

endmodule

// File: tb/tb_paint_cmd_rx.sv
// Bench for paint_cmd_rx: byte-level command model feeding a scoreboard,
// with a monitor that checks every wr_en / frame_err pulse.
module tb_paint_cmd_rx;

    localparam int         SYNC_STAGES = 2;
    localparam logic [2:0] RESET_COLOR = 3'b101;
    localparam int         LAT         = 1 + SYNC_STAGES + 2;

    typedef struct {
        bit         is_err;
        logic [7:0] wx;
        logic [7:0] wy;
        logic [2:0] col;
        logic       br;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    ev_t        sb[$];
    logic [7:0] frame_q[$];
    logic [7:0] m_wx, m_wy;
    logic [2:0] m_col;
    logic       m_br;

    paint_cmd_rx_if bus();

    paint_cmd_rx #(.SYNC_STAGES(SYNC_STAGES), .RESET_COLOR(RESET_COLOR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_wx  = '0;
        m_wy  = '0;
        m_col = RESET_COLOR;
        m_br  = 1'b0;
    endtask

    task automatic push_ev(input bit is_err, input int at);
        ev_t e;
        e.is_err = is_err;
        e.wx     = m_wx;
        e.wy     = m_wy;
        e.col    = m_col;
        e.br     = m_br;
        e.cyc    = at;
        sb.push_back(e);
    endtask

    // Command k of frame_q has just been fully clocked in.
    task automatic model_cmd(input int k, input int at);
        logic [7:0] c;
        c = frame_q[3*k];
        if (c[7:4] == 4'h1) begin
            m_wx = frame_q[3*k+1];
            m_wy = frame_q[3*k+2];
            push_ev(1'b0, at);
        end else if (c[7:4] == 4'h2) begin
            m_col = c[2:0];
            m_br  = c[3];
        end else begin
            push_ev(1'b1, at);
        end
    endtask

    task automatic check_state();
        chk("wx_held", bus.wx, m_wx);
        chk("wy_held", bus.wy, m_wy);
        chk("color_held", bus.new_color, m_col);
        chk("brush_held", bus.brush, m_br);
    endtask

    // Shift nbits of frame_q at sck = clk/8; optionally close the frame.
    task automatic frame(input int nbits, input bit close);
        logic [7:0] b;
        bus.cs = 1'b0;
        wait_cyc(4);
        for (int i = 0; i < nbits; i++) begin
            b       = frame_q[i/8];
            bus.sdi = b[7 - (i % 8)];
            bus.sck = 1'b0;
            wait_cyc(4);
            bus.sck = 1'b1;
            if ((i + 1) % 24 == 0) model_cmd(i / 24, cyc + LAT);
            wait_cyc(4);
        end
        if (close) begin
            bus.sck = 1'b0;
            wait_cyc(4);
            bus.cs = 1'b1;
            if (nbits % 24 != 0) push_ev(1'b1, cyc + LAT);
            wait_cyc(12);
            check_state();
        end
    endtask

    task automatic load3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        frame_q.push_back(a);
        frame_q.push_back(b);
        frame_q.push_back(c);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset && (bus.wr_en || bus.frame_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, bus.wr_en, bus.frame_err}, 32'd0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("pulse_kind", {30'd0, bus.wr_en, bus.frame_err}, {30'd0, ~e.is_err, e.is_err});
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_wx", bus.wx, e.wx);
                chk("pulse_wy", bus.wy, e.wy);
                chk("pulse_color", bus.new_color, e.col);
                chk("pulse_brush", bus.brush, e.br);
            end
        end
    end

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset   = 1'b0;
        bus.cs  = 1'b1;
        bus.sck = 1'b0;
        bus.sdi = 1'b0;
        model_reset();
        wait_cyc(3);
        chk("rst_wr_en", bus.wr_en, 1'b0);
        chk("rst_frame_err", bus.frame_err, 1'b0);
        reset = 1'b1;
        wait_cyc(50);
        chk("idle_wr_en", bus.wr_en, 1'b0);
        check_state();

        // Plain PAINT.
        frame_q.delete();
        load3(8'h10, 8'h40, 8'h21);
        frame(24, 1);

        // SET then PAINT in one frame.
        frame_q.delete();
        load3(8'h2A, 8'h00, 8'h00);
        load3(8'h10, 8'h05, 8'h06);
        frame(48, 1);

        // Early cs rise after 13 bits, then a corner-address PAINT.
        frame_q.delete();
        load3(8'h10, 8'h11, 8'h22);
        frame(13, 1);
        frame_q.delete();
        load3(8'h10, 8'hFF, 8'hFF);
        frame(24, 1);

        // Unknown opcode.
        frame_q.delete();
        load3(8'h70, 8'h01, 8'h02);
        frame(24, 1);

        // Reset between bytes 1 and 2, then a full PAINT.
        frame_q.delete();
        load3(8'h10, 8'h03, 8'h04);
        frame(8, 0);
        reset   = 1'b0;
        bus.cs  = 1'b1;
        bus.sck = 1'b0;
        model_reset();
        wait_cyc(5);
        check_state();
        reset = 1'b1;
        wait_cyc(5);
        frame(24, 1);

        // Randomised frames: mixed opcodes, some truncated.
        for (int f = 0; f < 25; f++) begin
            int ncmd, nbits;
            frame_q.delete();
            ncmd = $urandom_range(1, 3);
            for (int k = 0; k < ncmd; k++) begin
                int r;
                logic [7:0] c;
                r = $urandom_range(0, 9);
                c = 8'($urandom);
                if (r < 5)      c = {4'h1, c[3:0]};
                else if (r < 8) c = {4'h2, c[3:0]};
                load3(c, 8'($urandom), 8'($urandom));
            end
            nbits = 24 * ncmd;
            if ($urandom_range(0, 4) == 0) nbits = $urandom_range(1, 24 * ncmd - 1);
            frame(nbits, 1);
        end

        for (int t = 0; t < 20 && sb.size() != 0; t++) wait_cyc(1);
        chk("scoreboard_drain", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/paint_cmd_rx.md
# paint_cmd_rx

SPI-slave command receiver for the paint display. It sits directly upstream of the pixel store and colour decoder, and turns 3-byte commands from the microcontroller into pixel writes. Serial inputs are asynchronous to the 25.175 MHz VGA pixel clock, so they are synchronised and edge-detected in that domain. Outputs are one-cycle write pulses with pixel address, plus a held colour/brush state.

## Interface
- SYNC_STAGES, 2: synchroniser depth on sck, sdi, cs (legal 2–3).
- RESET_COLOR, 3'b101: colour code loaded into new_color at reset.
- clk  input  1  25.175 MHz pixel clock from the PLL; the only clock.
- reset  input  1  asynchronous, active-low reset (low = reset).
- sck  input  1  SPI clock, mode 0; sdi sampled on rising edge; max rate clk/8.
- sdi  input  1  SPI data, MSB first.
- cs  input  1  chip select, active low; frames a stream of whole 3-byte commands.
- wr_en  output  1  one-cycle pulse: write new_color at (wx, wy).
- wx  output  8  pixel x of the last PAINT command.
- wy  output  8  pixel y of the last PAINT command.
- new_color  output  3  current paint colour code.
- brush  output  1  current brush flag.
- frame_err  output  1  one-cycle pulse: partial or invalid command discarded.

## Operation
- sck, sdi and cs each pass through a SYNC_STAGES flop chain, plus one history flop on sck.
- An sck rise is detected when the synchronised value is 1 and the history value is 0.
- States:
  - IDLE: synchronised cs high; counters cleared.
  - SHIFT: entered when synchronised cs goes low. On each sck rise, shift sdi into an 8-bit shift register and increment bit_cnt (3 bits).
  - When bit_cnt wraps 7→0, the completed byte is stored by byte_cnt (0..2) into cmd, xb or yb.
  - After byte 2, decode the command, clear byte_cnt and stay in SHIFT. Back-to-back commands within one cs frame are legal.
- Command byte cmd[7:4] is the opcode:
  - 4'h1 PAINT: wx←xb, wy←yb, wr_en pulses. Colour and brush are unchanged; cmd[3:0] is ignored.
  - 4'h2 SET: new_color←cmd[2:0], brush←cmd[3]. xb and yb are ignored; no wr_en.
  - Any other opcode: discard the command; frame_err pulses; no output changes.
- cs rising while bit_cnt≠0 or byte_cnt≠0: discard the partial command, frame_err pulses, go to IDLE.
- cs rising on a clean command boundary: go to IDLE silently.
- An sck rise and a cs rise detected in the same cycle: the cs rise wins; that bit is dropped.
- sck edges while cs is high are ignored.
- Reset asserted mid-command: all state is cleared asynchronously; any partial command is lost with no frame_err.
- wx and wy are full 8-bit values with no range check. The pixel store handles addresses outside the visible area.

## Timing
- Reset values: wr_en=0, frame_err=0, wx=0, wy=0, new_color=RESET_COLOR, brush=0. FSM is in IDLE with counters at 0.
- All outputs are registered; no combinational path from any input pin.
- Latency, defined from the clk edge at which the first synchroniser flop captures the 24th sck rise:
  - wr_en, and the wx/wy/new_color/brush updates, take effect SYNC_STAGES+2 cycles later (4 cycles at default).
  - frame_err for a bad opcode has the same latency.
  - frame_err for an early cs rise follows the same rule, measured from the cs rise.
- wx and wy become valid in the same cycle wr_en is high and hold until the next PAINT.
- Minimum spacing between wr_en pulses is 24 sck periods, which is ≥192 clk cycles.
- No backpressure: the downstream stage must accept wr_en in any cycle.

## Test plan
- Reset release, no traffic → all outputs at reset values; wr_en never pulses.
- One cs frame with bytes 8'h10, 8'h40, 8'h21 at sck=clk/8 → one wr_en pulse with wx=8'h40, wy=8'h21, new_color=3'b101, brush=0; the pulse occurs 4 cycles after the last sck rise is captured.
- Frame 8'h2A, 8'h00, 8'h00, then 8'h10, 8'h05, 8'h06 in the same cs frame → after the SET, new_color=3'b010 and brush=1 with no wr_en; the PAINT then gives exactly one wr_en with wx=5, wy=6.
- cs raised after 13 bits → frame_err one-cycle pulse, no wr_en. A following valid PAINT of 8'h10, 8'hFF, 8'hFF gives wx=wy=8'hFF.
- Opcode 8'h70, 8'h01, 8'h02 → frame_err pulse; wx, wy, new_color and brush unchanged.
- Reset asserted between bytes 1 and 2 and released, then a full PAINT of 8'h10, 8'h03, 8'h04 → exactly one wr_en with wx=3, wy=4; no frame_err at any point.
